seg7_scan_driver: RTL and testbench

Four-digit multiplexed seven-segment display driver. Sits directly downstream of the binary-to-BCD converters and takes packed BCD digits, typically tens/ones pairs for two 0–99 values. It time-multiplexes the digits onto one shared segment bus, with leading-zero blanking, per-digit blink and decimal point, and anti-ghosting dead time. All outputs are registered and drive the board pins directly.

---
 rtl/seg7_scan_driver_pkg.sv | 34 +++
 rtl/seg7_decoder.sv | 26 ++
 rtl/seg7_scan_driver.sv | 118 +++++++++++
 tb/tb_seg7_scan_driver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// digit count, the latched display configuration and the blanking rule.
package seg7_scan_driver_pkg;

    localparam int N_DIG = 4;

    // Active-high patterns, bit order gfedcba
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef struct packed {
        logic [4*N_DIG-1:0] bcd;
        logic [N_DIG-1:0]   blink;
        logic [N_DIG-1:0]   dp;
        logic               blank_lz;
    } disp_cfg_t;

    // Digit idx is a leading zero when it and every digit to its left are 0.
    function automatic logic lz_blanked(input logic [4*N_DIG-1:0] bcd,
                                        input logic [1:0]         idx,
                                        input logic               en);
        return en && (idx != 2'd0) && ((bcd >> {idx, 2'b00}) == '0);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to seven-segment decoder; non-decimal nibbles show a dash.
module seg7_decoder
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] pat_o
);

    always_comb begin
        pat_o = SEG_DASH;
        case (bcd_i)
            4'd0:    pat_o = SEG_0;
            4'd1:    pat_o = SEG_1;
            4'd2:    pat_o = SEG_2;
            4'd3:    pat_o = SEG_3;
            4'd4:    pat_o = SEG_4;
            4'd5:    pat_o = SEG_5;
            4'd6:    pat_o = SEG_6;
            4'd7:    pat_o = SEG_7;
            4'd8:    pat_o = SEG_8;
            4'd9:    pat_o = SEG_9;
            default: pat_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with leading-zero blanking,
// per-digit blink and decimal point, and dead time between digit slots.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYC    = 16,
    parameter int BLINK_SLOTS = 500,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig_sel,
    output logic        frame_done
);

    localparam int   CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int   BL_W    = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic SEG_INV = (SEG_ACT_LOW != 0);
    localparam logic DIG_INV = (DIG_ACT_LOW != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [BL_W-1:0]  bl_q, bl_d;
    logic             phase_q, phase_d;
    disp_cfg_t        shadow_q, shadow_d;
    disp_cfg_t        disp_q, disp_d;

    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       sel_q, sel_d;
    logic             fd_q, fd_d;

    logic             tick;
    logic             bl_wrap;
    logic [3:0]       nib;
    logic [6:0]       pat;
    logic             blanked;
    logic             blink_off;

    seg7_decoder u_dec (
        .bcd_i (nib),
        .pat_o (pat)
    );

    always_comb begin
        tick    = (cnt_q == CNT_W'(SCAN_DIV - 1));
        bl_wrap = (bl_q == BL_W'(BLINK_SLOTS - 1));

        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        bl_d    = bl_q;
        if (tick) bl_d = bl_wrap ? '0 : bl_q + 1'b1;
        phase_d = phase_q ^ (tick & bl_wrap);

        shadow_d = shadow_q;
        if (load) shadow_d = '{bcd: bcd_in, blink: blink_mask, dp: dp_mask, blank_lz: blank_lz};
        // The slot about to start takes the shadow as it stood before any coincident load.
        disp_d = tick ? shadow_q : disp_q;
    end

    always_comb begin
        nib       = disp_q.bcd[{idx_q, 2'b00} +: 4];
        blanked   = lz_blanked(disp_q.bcd, idx_q, disp_q.blank_lz);
        blink_off = phase_q & disp_q.blink[idx_q];

        seg_d = ((blink_off || blanked) ? 7'h00 : pat) ^ {7{SEG_INV}};
        dp_d  = (disp_q.dp[idx_q] & ~blink_off) ^ SEG_INV;
        sel_d = ((cnt_q >= CNT_W'(DEAD_CYC)) ? (4'b0001 << idx_q) : 4'b0000) ^ {4{DIG_INV}};
        fd_d  = tick && (idx_q == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            bl_q     <= '0;
            phase_q  <= 1'b0;
            shadow_q <= '0;
            disp_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bl_q     <= bl_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= {7{SEG_INV}};
            dp_q  <= SEG_INV;
            sel_q <= {4{DIG_INV}};
            fd_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            sel_q <= sel_d;
            fd_q  <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_sel    = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a cycle-indexed display model.
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BL = 4;
    localparam logic [12:0] INACT = {7'h7F, 1'b1, 4'hF, 1'b0};

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  blink;
        logic [3:0]  dp;
        logic        blz;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_driver #(
        .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_SLOTS(BL),
        .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .dp_mask(dp_mask),
        .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_pattern(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h40;
        endcase
    endfunction

    // Outputs during the cycle after state (slot s, count c) with cfg latched for slot s.
    function automatic logic [12:0] model_out(input int c, input int s, input cfg_t cfg);
        int         idx;
        bit         ph, blank, off;
        logic [6:0] pat;
        logic [3:0] sel;
        logic       dpo;
        idx   = s % 4;
        ph    = ((s / BL) % 2) == 1;
        pat   = seg_pattern(4'(cfg.bcd >> (4 * idx)));
        blank = cfg.blz && (idx > 0);
        for (int j = idx; j < 4; j++)
            if (4'(cfg.bcd >> (4 * j)) != 4'd0) blank = 0;
        off = ph && cfg.blink[idx];
        if (off || blank) pat = 7'h00;
        dpo = cfg.dp[idx] && !off;
        sel = (c >= DC) ? 4'(1 << idx) : 4'd0;
        return {~pat, ~dpo, ~sel, (c == SD - 1) && (idx == 3)};
    endfunction

    int          cyc;
    cfg_t        m_sh, m_cfg;
    logic [12:0] exp_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc   <= 0;
            m_sh  <= '0;
            m_cfg <= '0;
            exp_v <= INACT;
        end else begin
            exp_v <= model_out(cyc % SD, cyc / SD, m_cfg);
            if (cyc % SD == SD - 1) m_cfg <= m_sh;
            if (load) m_sh <= {bcd_in, blink_mask, dp_mask, blank_lz};
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cyc %0d, t=%0t)", nm, act, req, cyc, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model seg",   {1'b0, seg},     {1'b0, exp_v[12:6]});
        chk("model dp",    {7'b0, dp},      {7'b0, exp_v[5]});
        chk("model dig",   {4'b0, dig_sel}, {4'b0, exp_v[4:1]});
        chk("model frame", {7'b0, frame_done}, {7'b0, exp_v[0]});
    end

    task automatic at_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_fail++;
            n_tests++;
            $display("FAIL wait: reached cyc %0d, required %0d", cyc, n);
        end
    endtask

    task automatic at_slot(input int s, input int c);
        at_cyc(SD * s + c + 1);
    endtask

    task automatic do_load(input int n, input logic [15:0] b, input logic z,
                           input logic [3:0] bm, input logic [3:0] dm);
        at_cyc(n);
        load = 1'b1; bcd_in = b; blank_lz = z; blink_mask = bm; dp_mask = dm;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic chk_inactive(input string nm);
        chk({nm, " seg"},   {1'b0, seg},        8'h7F);
        chk({nm, " dp"},    {7'b0, dp},         8'h01);
        chk({nm, " dig"},   {4'b0, dig_sel},    8'h0F);
        chk({nm, " frame"}, {7'b0, frame_done}, 8'h00);
    endtask

    initial begin
        logic [15:0] rb;
        int          r;

        repeat (3) @(negedge clk);
        chk_inactive("reset");
        rst_n = 1'b1;

        // Blink + 1234 scan
        do_load(1, 16'h1234, 1'b0, 4'b0001, 4'b0000);
        at_slot(0, 1);  chk("dead slot0", {4'b0, dig_sel}, 8'h0F);
        at_slot(0, 2);  chk("slot0 dig", {4'b0, dig_sel}, 8'h0E);
                        chk("slot0 seg", {1'b0, seg}, 8'h40);
        at_slot(1, 2);  chk("slot1 seg", {1'b0, seg}, 8'h30);
                        chk("slot1 dig", {4'b0, dig_sel}, 8'h0D);
        at_slot(1, 7);  chk("slot1 end seg", {1'b0, seg}, 8'h30);
        at_slot(2, 4);  chk("slot2 seg", {1'b0, seg}, 8'h24);
                        chk("slot2 dig", {4'b0, dig_sel}, 8'h0B);
        at_slot(3, 4);  chk("slot3 seg", {1'b0, seg}, 8'h79);
                        chk("slot3 dig", {4'b0, dig_sel}, 8'h07);
        at_cyc(31);     chk("frame pre", {7'b0, frame_done}, 8'h00);
        at_cyc(32);     chk("frame hit", {7'b0, frame_done}, 8'h01);
        at_cyc(33);     chk("frame post", {7'b0, frame_done}, 8'h00);
        at_slot(4, 4);  chk("blink off seg", {1'b0, seg}, 8'h7F);
                        chk("blink off dp", {7'b0, dp}, 8'h01);
                        chk("blink off dig", {4'b0, dig_sel}, 8'h0E);
        at_slot(5, 4);  chk("blink other", {1'b0, seg}, 8'h30);
        at_cyc(64);     chk("frame 2", {7'b0, frame_done}, 8'h01);
        at_slot(8, 4);  chk("blink on again", {1'b0, seg}, 8'h19);
        at_slot(12, 4); chk("blink off again", {1'b0, seg}, 8'h7F);

        // Leading-zero blanking
        do_load(124, 16'h0007, 1'b1, 4'b0000, 4'b0000);
        at_slot(16, 4); chk("lz 0007 d0", {1'b0, seg}, 8'h78);
        at_slot(17, 4); chk("lz 0007 d1", {1'b0, seg}, 8'h7F);
        at_slot(18, 4); chk("lz 0007 d2", {1'b0, seg}, 8'h7F);
        at_slot(19, 4); chk("lz 0007 d3", {1'b0, seg}, 8'h7F);
        do_load(158, 16'h0100, 1'b1, 4'b0000, 4'b0000);
        at_slot(20, 4); chk("lz 0100 d0", {1'b0, seg}, 8'h40);
        at_slot(21, 4); chk("lz 0100 d1", {1'b0, seg}, 8'h40);
        at_slot(22, 4); chk("lz 0100 d2", {1'b0, seg}, 8'h79);
        at_slot(23, 4); chk("lz 0100 d3", {1'b0, seg}, 8'h7F);
        do_load(190, 16'h0000, 1'b1, 4'b0000, 4'b0000);
        at_slot(24, 4); chk("lz 0000 d0", {1'b0, seg}, 8'h40);
        at_slot(25, 4); chk("lz 0000 d1", {1'b0, seg}, 8'h7F);

        // Invalid nibble and decimal point
        do_load(206, 16'h00A0, 1'b0, 4'b0000, 4'b0010);
        at_slot(28, 4); chk("dp d0 seg", {1'b0, seg}, 8'h40);
                        chk("dp d0 dp", {7'b0, dp}, 8'h01);
        at_slot(29, 4); chk("dash seg", {1'b0, seg}, 8'h3F);
                        chk("dash dp", {7'b0, dp}, 8'h00);

        // Mid-slot and tick-coincident loads
        do_load(260, 16'h8888, 1'b0, 4'b0000, 4'b0000);
        at_slot(32, 6); chk("midload held", {1'b0, seg}, 8'h40);
        at_slot(33, 4); chk("midload next", {1'b0, seg}, 8'h00);
        do_load(271, 16'h9999, 1'b0, 4'b0000, 4'b0000);
        at_slot(34, 4); chk("tickload old", {1'b0, seg}, 8'h00);
        at_slot(35, 4); chk("tickload new", {1'b0, seg}, 8'h10);

        // Asynchronous reset mid-slot
        at_cyc(300);
        #2 rst_n = 1'b0;
        #1 chk_inactive("async reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        at_cyc(2); chk("rerelease dead", {4'b0, dig_sel}, 8'h0F);
        at_cyc(3); chk("rerelease dig", {4'b0, dig_sel}, 8'h0E);
                   chk("rerelease seg", {1'b0, seg}, 8'h40);

        // Randomized loads
        repeat (2000) begin
            @(negedge clk);
            load = ($urandom_range(0, 4) == 0);
            rb = '0;
            for (int k = 0; k < 4; k++) begin
                r = $urandom_range(0, 15);
                if (r < 5)       rb[4*k +: 4] = 4'd0;
                else if (r < 14) rb[4*k +: 4] = 4'($urandom_range(0, 9));
                else             rb[4*k +: 4] = 4'($urandom_range(10, 15));
            end
            bcd_in     = rb;
            blank_lz   = 1'($urandom_range(0, 1));
            blink_mask = 4'($urandom_range(0, 15));
            dp_mask    = 4'($urandom_range(0, 15));
        end
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
